sram_req_arbiter: RTL and testbench

- Shares one downstream SRAM-like port between the IF instruction requester and the MEM data requester.
- Sits between the pipeline stages and the memory bridge.
- Grants one request per cycle, holding the grant until the downstream accepts it.
- Tracks outstanding transactions in a source-ID FIFO and routes each `data_ok`/`rdata` back, in order, to the requester that issued it.

---
 rtl/sram_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// Two-master arbiter in front of one SRAM-like port. MEM data requests win over
// IF fetches, a presented-but-unaccepted request stays locked until accepted,
// and a source-ID FIFO steers each in-order response back to its requester.
module sram_req_arbiter #(
   parameter int unsigned OUTSTANDING = 4,
   parameter int unsigned PTR_W       = 2
) (
   input  logic        clk,
   input  logic        rst,
   // IF requester
   input  logic        inst_sram_req,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // MEM requester
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   // Downstream port
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {SrcInst = 1'b0, SrcData = 1'b1} src_e;

   localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(OUTSTANDING);

   // One bit per outstanding transaction: 1 = DATA, 0 = INST
   logic [OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]         count_q, count_d;
   logic                   lock_valid_q, lock_valid_d;
   src_e                   lock_src_q, lock_src_d;
   // Responses arriving with nothing outstanding; observable only in simulation
   logic [31:0]            err_cnt_q, err_cnt_d;

   src_e src;
   logic req_sel;
   logic full;
   logic empty;
   logic fire;
   logic pop;
   logic head;

   logic unused_err_cnt;
   assign unused_err_cnt = ^err_cnt_q;

   // Source selection, handshake qualifiers and FIFO status
   always_comb begin
      src = SrcInst;
      if (lock_valid_q) begin
         src = lock_src_q;
      end else if (data_sram_req) begin
         src = SrcData;
      end
      req_sel = (src == SrcData) ? data_sram_req : inst_sram_req;
      full    = (count_q == FullCount);
      empty   = (count_q == '0);
      fire    = mem_req & mem_addr_ok;
      pop     = ~rst & mem_data_ok & ~empty;
      head    = fifo_q[rd_ptr_q];
   end

   // Downstream request mux and per-requester handshake outputs
   always_comb begin
      mem_req   = ~rst & req_sel & ~full;
      mem_wr    = 1'b0;
      mem_size  = 2'd2;
      mem_wstrb = 4'h0;
      mem_addr  = inst_sram_addr;
      mem_wdata = 32'h0;
      if (src == SrcData) begin
         mem_wr    = data_sram_wr;
         mem_size  = data_sram_size;
         mem_wstrb = data_sram_wstrb;
         mem_addr  = data_sram_addr;
         mem_wdata = data_sram_wdata;
      end
      inst_sram_addr_ok = fire & (src == SrcInst);
      data_sram_addr_ok = fire & (src == SrcData);
      inst_sram_data_ok = pop & ~head;
      data_sram_data_ok = pop & head;
      // Read data is a plain fan-out; the data_ok strobes say who owns it
      inst_sram_rdata   = mem_rdata;
      data_sram_rdata   = mem_rdata;
   end

   // Next-state for the source FIFO, lock and drop counter
   always_comb begin
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      lock_valid_d = lock_valid_q;
      lock_src_d   = lock_src_q;
      err_cnt_d    = err_cnt_q;

      if (fire) begin
         fifo_d[wr_ptr_q] = (src == SrcData);
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({fire, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      if (mem_data_ok && empty) begin
         err_cnt_d = err_cnt_q + 32'd1;
      end

      // A presented request must not change until accepted, so pin the source
      if (fire) begin
         lock_valid_d = 1'b0;
      end else if (mem_req && !mem_addr_ok) begin
         lock_valid_d = 1'b1;
         lock_src_d   = src;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         lock_valid_q <= 1'b0;
         lock_src_q   <= SrcInst;
         err_cnt_q    <= '0;
      end else begin
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         lock_valid_q <= lock_valid_d;
         lock_src_q   <= lock_src_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter. Stimulus pushes expected grants and
// responses into queues; a negedge monitor pops and compares them.
module tb_sram_req_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   sram_req_arbiter #(
      .OUTSTANDING (4),
      .PTR_W       (2)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .mem_req           (mem_req),
      .mem_wr            (mem_wr),
      .mem_size          (mem_size),
      .mem_wstrb         (mem_wstrb),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_addr_ok       (mem_addr_ok),
      .mem_data_ok       (mem_data_ok),
      .mem_rdata         (mem_rdata)
   );

   typedef struct packed {
      logic        is_data;
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } grant_t;

   typedef struct packed {
      logic        inst_ok;
      logic        data_ok;
      logic [31:0] rdata;
   } resp_t;

   grant_t gq[$];
   resp_t  rq[$];
   grant_t mon_g;
   resp_t  mon_r;
   int     n_checks = 0;
   int     n_fail   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted request and every downstream response is scored
   always @(negedge clk) begin
      if (!rst) begin
         if ((mem_req && mem_addr_ok) || inst_sram_addr_ok || data_sram_addr_ok) begin
            if (gq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_grant: got addr %h with nothing expected", mem_addr);
            end else begin
               mon_g = gq.pop_front();
               check("grant",
                     {data_sram_addr_ok, inst_sram_addr_ok, mem_req, mem_wr, mem_size,
                      mem_wstrb, mem_addr, mem_wdata},
                     {mon_g.is_data, ~mon_g.is_data, 1'b1, mon_g.wr, mon_g.size,
                      mon_g.wstrb, mon_g.addr, mon_g.wdata});
            end
         end
         if (mem_data_ok || inst_sram_data_ok || data_sram_data_ok) begin
            if (rq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: got inst_ok %b data_ok %b with nothing expected",
                        inst_sram_data_ok, data_sram_data_ok);
            end else begin
               mon_r = rq.pop_front();
               check("resp",
                     {inst_sram_data_ok, data_sram_data_ok, inst_sram_rdata, data_sram_rdata},
                     {mon_r.inst_ok, mon_r.data_ok, mon_r.rdata, mon_r.rdata});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic exp_inst(input logic [31:0] a);
      gq.push_back('{1'b0, 1'b0, 2'd2, 4'h0, a, 32'h0});
   endtask

   task automatic exp_data(input logic wr, input logic [1:0] sz, input logic [3:0] ws,
                           input logic [31:0] a, input logic [31:0] wd);
      gq.push_back('{1'b1, wr, sz, ws, a, wd});
   endtask

   task automatic drive_data(input logic wr, input logic [1:0] sz, input logic [3:0] ws,
                             input logic [31:0] a, input logic [31:0] wd);
      data_sram_req   = 1'b1;
      data_sram_wr    = wr;
      data_sram_size  = sz;
      data_sram_wstrb = ws;
      data_sram_addr  = a;
      data_sram_wdata = wd;
   endtask

   task automatic respond(input logic i_ok, input logic d_ok, input logic [31:0] r);
      rq.push_back('{i_ok, d_ok, r});
      mem_data_ok = 1'b1;
      mem_rdata   = r;
      tick();
      mem_data_ok = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      inst_sram_req   = 1'b1;
      inst_sram_addr  = 32'hbfc0_0000;
      data_sram_req   = 1'b0;
      data_sram_wr    = 1'b0;
      data_sram_size  = 2'd2;
      data_sram_wstrb = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;
      mem_addr_ok     = 1'b1;
      mem_data_ok     = 1'b1;
      mem_rdata       = 32'h5a5a_1234;
      drive_data(1'b0, 2'd2, 4'h0, 32'h1c00_0100, 32'h0);

      // Reset: everything quiet, rdata passes straight through
      tick();
      settle();
      check("reset_strobes",
            {mem_req, inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok, data_sram_data_ok},
            5'b0);
      check("reset_inst_rdata", inst_sram_rdata, 32'h5a5a_1234);
      check("reset_data_rdata", data_sram_rdata, 32'h5a5a_1234);
      tick();

      // Priority: DATA then INST
      rst         = 1'b0;
      mem_data_ok = 1'b0;
      exp_data(1'b0, 2'd2, 4'h0, 32'h1c00_0100, 32'h0);
      exp_inst(32'hbfc0_0000);
      settle();
      check("prio_data_first", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b10);
      tick();
      data_sram_req = 1'b0;
      settle();
      check("prio_inst_second", {data_sram_addr_ok, inst_sram_addr_ok}, 2'b01);
      tick();
      inst_sram_req = 1'b0;
      respond(1'b0, 1'b1, 32'h1111_1111);
      respond(1'b1, 1'b0, 32'h2222_2222);

      // Lock: INST stalled three cycles, DATA arrives in cycle 2
      mem_addr_ok    = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0010;
      settle();
      check("lock_c1", {mem_req, mem_addr}, {1'b1, 32'hbfc0_0010});
      tick();
      drive_data(1'b0, 2'd2, 4'h0, 32'h1c00_0200, 32'h0);
      settle();
      check("lock_c2", {mem_req, mem_addr, data_sram_addr_ok}, {1'b1, 32'hbfc0_0010, 1'b0});
      tick();
      settle();
      check("lock_c3", {mem_req, mem_addr, data_sram_addr_ok}, {1'b1, 32'hbfc0_0010, 1'b0});
      tick();
      mem_addr_ok = 1'b1;
      exp_inst(32'hbfc0_0010);
      exp_data(1'b0, 2'd2, 4'h0, 32'h1c00_0200, 32'h0);
      settle();
      check("lock_inst_accept", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
      tick();
      inst_sram_req = 1'b0;
      settle();
      check("lock_data_next", {inst_sram_addr_ok, data_sram_addr_ok}, 2'b01);
      tick();
      data_sram_req = 1'b0;
      respond(1'b1, 1'b0, 32'h3333_3333);
      respond(1'b0, 1'b1, 32'h4444_4444);

      // Full: four INST reads outstanding block a fifth
      inst_sram_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         inst_sram_addr = 32'hbfc0_0100 + 32'(4 * i);
         exp_inst(inst_sram_addr);
         tick();
      end
      inst_sram_addr = 32'hbfc0_0110;
      settle();
      check("full_block", {mem_req, inst_sram_addr_ok}, 2'b00);
      tick();
      settle();
      check("full_hold", {mem_req, inst_sram_addr_ok}, 2'b00);
      tick();
      rq.push_back('{1'b1, 1'b0, 32'h5555_0000});
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h5555_0000;
      exp_inst(32'hbfc0_0110);
      settle();
      check("full_pop_same_cycle", mem_req, 1'b0);
      tick();
      mem_data_ok = 1'b0;
      settle();
      check("full_resume", {mem_req, inst_sram_addr_ok}, 2'b11);
      tick();
      inst_sram_req = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         respond(1'b1, 1'b0, 32'h5555_0000 + 32'(i));
      end

      // Simultaneous push and pop with two outstanding
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0200;
      exp_inst(32'hbfc0_0200);
      tick();
      inst_sram_req = 1'b0;
      drive_data(1'b0, 2'd2, 4'h0, 32'h1c00_0300, 32'h0);
      exp_data(1'b0, 2'd2, 4'h0, 32'h1c00_0300, 32'h0);
      tick();
      data_sram_addr = 32'h1c00_0304;
      exp_data(1'b0, 2'd2, 4'h0, 32'h1c00_0304, 32'h0);
      rq.push_back('{1'b1, 1'b0, 32'h6666_0000});
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h6666_0000;
      settle();
      check("pushpop_old_head", {inst_sram_data_ok, data_sram_data_ok}, 2'b10);
      tick();
      data_sram_req  = 1'b0;
      mem_data_ok    = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0204;
      exp_inst(32'hbfc0_0204);
      tick();
      inst_sram_addr = 32'hbfc0_0208;
      exp_inst(32'hbfc0_0208);
      tick();
      inst_sram_addr = 32'hbfc0_020c;
      settle();
      check("pushpop_count_full", mem_req, 1'b0);
      tick();
      inst_sram_req = 1'b0;
      respond(1'b0, 1'b1, 32'h6666_0001);
      respond(1'b0, 1'b1, 32'h6666_0002);
      respond(1'b1, 1'b0, 32'h6666_0003);
      respond(1'b1, 1'b0, 32'h6666_0004);

      // Byte write passes through unchanged
      drive_data(1'b1, 2'd0, 4'b0100, 32'h1c00_0010, 32'h00ab_0000);
      exp_data(1'b1, 2'd0, 4'b0100, 32'h1c00_0010, 32'h00ab_0000);
      settle();
      check("write_fields", {mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata},
            {1'b1, 1'b1, 2'd0, 4'b0100, 32'h1c00_0010, 32'h00ab_0000});
      tick();
      data_sram_req = 1'b0;
      respond(1'b0, 1'b1, 32'h0000_0000);

      // Reset with three outstanding and a locked DATA request
      inst_sram_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         inst_sram_addr = 32'hbfc0_0300 + 32'(4 * i);
         exp_inst(inst_sram_addr);
         tick();
      end
      inst_sram_req = 1'b0;
      mem_addr_ok   = 1'b0;
      drive_data(1'b0, 2'd2, 4'h0, 32'h1c00_0400, 32'h0);
      settle();
      check("midrst_pending", {mem_req, mem_addr}, {1'b1, 32'h1c00_0400});
      tick();
      rst = 1'b1;
      settle();
      check("midrst_quiet", {mem_req, inst_sram_data_ok, data_sram_data_ok}, 3'b0);
      tick();
      rst            = 1'b0;
      data_sram_req  = 1'b0;
      inst_sram_req  = 1'b1;
      inst_sram_addr = 32'hbfc0_0400;
      rq.push_back('{1'b0, 1'b0, 32'h7777_0000});
      mem_data_ok = 1'b1;
      mem_rdata   = 32'h7777_0000;
      settle();
      check("midrst_unlocked", {mem_req, mem_addr}, {1'b1, 32'hbfc0_0400});
      tick();
      mem_data_ok = 1'b0;
      mem_addr_ok = 1'b1;
      exp_inst(32'hbfc0_0400);
      tick();
      inst_sram_req = 1'b0;
      mem_addr_ok   = 1'b0;
      respond(1'b1, 1'b0, 32'h7777_0001);

      // Drain with a bounded wait, then confirm nothing was left unmatched
      for (int i = 0; i < 20 && (gq.size() != 0 || rq.size() != 0); i++) begin
         tick();
      end
      check("grant_queue_empty", 128'(gq.size()), 128'd0);
      check("resp_queue_empty", 128'(rq.size()), 128'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
